// File: rtl/plotter_pkg.sv
// Shared constants, colours and FSM state encoding for the paddle rectangle plotter.
package plotter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ERASE = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ERASE = ST_ERASE,
    S_DRAW  = ST_DRAW,
    S_DONE  = ST_DONE
  } plot_state_e;

  // Counter width for a 0..n-1 range; a 1-wide range still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_scan.sv
// Row-major column/row offset generator for a PW x PH rectangle; restarted via i_start.
module rect_scan
  import plotter_pkg::*;
#(
  parameter int PW = 8,
  parameter int PH = 2,
  localparam int CW = cnt_w(PW),
  localparam int RW = cnt_w(PH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_adv,
  output logic [CW-1:0] o_c,
  output logic [RW-1:0] o_r,
  output logic          o_last
);

  localparam logic [CW-1:0] C_END = CW'(PW - 1);
  localparam logic [RW-1:0] R_END = RW'(PH - 1);

  logic [CW-1:0] r_c;
  logic [RW-1:0] r_r;
  logic          w_c_end;

  assign w_c_end = (r_c == C_END);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_start) begin
      r_c <= '0;
      r_r <= '0;
    end else if (i_adv) begin
      if (w_c_end) begin
        r_c <= '0;
        r_r <= r_r + 1'b1;
      end else begin
        r_c <= r_c + 1'b1;
      end
    end
  end

  assign o_c    = r_c;
  assign o_r    = r_r;
  assign o_last = w_c_end && (r_r == R_END);

endmodule

// File: rtl/paddle_plotter.sv
// Erases the previous paddle rectangle and draws the new one, one pixel per clock, into vga_adapter.
// Optional build macro PLOTTER_SKIP_UNCHANGED_EN: a request for the unchanged position plots nothing.
//
// state | meaning
// IDLE  | waiting for i_req; outputs quiet
// ERASE | scanning old rectangle in BG
// DRAW  | scanning target rectangle in FG
// DONE  | committing target as old; done pulse goes out next edge
module paddle_plotter
  import plotter_pkg::*;
#(
  parameter int         PW    = 8,
  parameter int         PH    = 2,
  parameter int         X_MAX = SCREEN_W - 1,
  parameter int         Y_MAX = SCREEN_H - 1,
  parameter logic [2:0] FG    = COL_WHITE,
  parameter logic [2:0] BG    = COL_BLACK
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic [7:0] i_new_x,
  input  logic [6:0] i_new_y,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_vga_x,
  output logic [6:0] o_vga_y,
  output logic [2:0] o_vga_colour,
  output logic       o_vga_plot
);

  localparam int CW = cnt_w(PW);
  localparam int RW = cnt_w(PH);

  plot_state_e r_state, w_state_nxt;

  logic [7:0] r_tgt_x, r_old_x, r_vga_x, w_x_nxt, w_base_x;
  logic [6:0] r_tgt_y, r_old_y, r_vga_y, w_y_nxt, w_base_y;
  logic [2:0] r_vga_col, w_col_nxt;
  logic       r_have_old, r_busy, r_done, r_plot;
  logic       w_busy_nxt, w_done_nxt, w_plot_nxt;
  logic       w_start, w_adv, w_latch, w_commit, w_same, w_vis, w_last;
  logic [CW-1:0] w_c;
  logic [RW-1:0] w_r;
  logic [8:0] w_px;
  logic [7:0] w_py;

  rect_scan #(.PW(PW), .PH(PH)) u_scan (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (w_start),
    .i_adv   (w_adv),
    .o_c     (w_c),
    .o_r     (w_r),
    .o_last  (w_last)
  );

`ifdef PLOTTER_SKIP_UNCHANGED_EN
  assign w_same = (i_new_x == r_old_x) && (i_new_y == r_old_y);
`else
  assign w_same = 1'b0;
`endif

  assign w_base_x = (r_state == S_ERASE) ? r_old_x : r_tgt_x;
  assign w_base_y = (r_state == S_ERASE) ? r_old_y : r_tgt_y;
  // One bit wider so off-screen pixels never wrap back onto the screen.
  assign w_px  = {1'b0, w_base_x} + 9'(w_c);
  assign w_py  = {1'b0, w_base_y} + 8'(w_r);
  assign w_vis = (w_px <= 9'(X_MAX)) && (w_py <= 8'(Y_MAX));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_plot_nxt  = 1'b0;
    w_x_nxt     = r_vga_x;
    w_y_nxt     = r_vga_y;
    w_col_nxt   = r_vga_col;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (i_req) begin
          w_latch    = 1'b1;
          w_start    = 1'b1;
          w_busy_nxt = 1'b1;
          if (!r_have_old)  w_state_nxt = S_DRAW;
          else if (w_same)  w_state_nxt = S_DONE;
          else              w_state_nxt = S_ERASE;
        end
      end
      S_ERASE, S_DRAW: begin
        w_adv      = 1'b1;
        w_plot_nxt = w_vis;
        if (w_vis) begin
          w_x_nxt   = w_px[7:0];
          w_y_nxt   = w_py[6:0];
          w_col_nxt = (r_state == S_ERASE) ? BG : FG;
        end
        if (w_last) begin
          w_start     = 1'b1;
          w_state_nxt = (r_state == S_ERASE) ? S_DRAW : S_DONE;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tgt_x    <= '0;
      r_tgt_y    <= '0;
      r_old_x    <= '0;
      r_old_y    <= '0;
      r_have_old <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_plot     <= 1'b0;
      r_vga_x    <= '0;
      r_vga_y    <= '0;
      r_vga_col  <= '0;
    end else begin
      if (w_latch) begin
        r_tgt_x <= i_new_x;
        r_tgt_y <= i_new_y;
      end
      if (w_commit) begin
        r_old_x    <= r_tgt_x;
        r_old_y    <= r_tgt_y;
        r_have_old <= 1'b1;
      end
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_plot    <= w_plot_nxt;
      r_vga_x   <= w_x_nxt;
      r_vga_y   <= w_y_nxt;
      r_vga_col <= w_col_nxt;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_vga_x      = r_vga_x;
  assign o_vga_y      = r_vga_y;
  assign o_vga_colour = r_vga_col;
  assign o_vga_plot   = r_plot;

endmodule
